// File: rtl/seq_entry_ctrl.sv
// Button front-end for the 4-bit sequence detector: sync + debounce two keys, turn presses
// into bit strobes, latch the pattern per session, and keep history and saturating counters.
//   state  | meaning
//   S_IDLE | waiting for Start, Busy low
//   S_CLR  | one-cycle session clear, latch pattern, pulse Det_Clear
//   S_RUN  | accept one rising edge as a bit (or flag a conflict)
//   S_HOLD | wait for both debounced keys to be released
module seq_entry_ctrl #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter int          CNT_W      = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             P0,
    input  logic             P1,
    input  logic [3:0]       B,
    input  logic             Start,
    input  logic             Clear_Req,
    input  logic             Match,
    output logic             Bit_Valid,
    output logic             Bit_Value,
    output logic             Det_Clear,
    output logic [3:0]       Pattern,
    output logic [7:0]       History,
    output logic [CNT_W-1:0] Bit_Count,
    output logic [CNT_W-1:0] Match_Count,
    output logic             Conflict,
    output logic             Busy
);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [1:0][15:0] cnt_q, cnt_d;
    logic [1:0]       rise;
    logic             bit_valid_q, bit_valid_d, bit_value_q, bit_value_d;
    logic             conflict_q, conflict_d;
    logic [3:0]       pattern_q, pattern_d;
    logic [7:0]       history_q, history_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d, match_count_q, match_count_d;
    logic             take0, take1, match_en;

    always_comb begin
        sync1_d    = {P1, P0};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_CYCLES - 16'd1) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = 16'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = 16'd0;
            end
        end
        rise = deb_q & ~deb_prev_q;
    end

    // A rise only counts as a bit when the other key is released; anything else is a conflict.
    assign take0    = rise[0] & ~deb_q[1];
    assign take1    = rise[1] & ~deb_q[0];
    assign match_en = Match & ((state_q == S_RUN) | (state_q == S_HOLD));

    always_comb begin
        state_d       = state_q;
        bit_valid_d   = 1'b0;
        bit_value_d   = bit_value_q;
        conflict_d    = 1'b0;
        pattern_d     = pattern_q;
        history_d     = history_q;
        bit_count_d   = bit_count_q;
        match_count_d = match_count_q;

        if (match_en && match_count_q != {CNT_W{1'b1}})
            match_count_d = match_count_q + CNT_W'(1);

        case (state_q)
            S_IDLE: if (Start) state_d = S_CLR;
            S_CLR: begin
                pattern_d     = B;
                history_d     = 8'h00;
                bit_count_d   = '0;
                match_count_d = '0;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (!Clear_Req && (rise != 2'b00)) begin
                    state_d = S_HOLD;
                    if (take0 || take1) begin
                        bit_valid_d = 1'b1;
                        bit_value_d = take1;
                        history_d   = {history_q[6:0], take1};
                        if (bit_count_q != {CNT_W{1'b1}})
                            bit_count_d = bit_count_q + CNT_W'(1);
                    end else begin
                        conflict_d = 1'b1;
                    end
                end
            end
            S_HOLD:  if (deb_q == 2'b00) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (Clear_Req) state_d = S_CLR;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            sync1_q       <= 2'b00;
            sync2_q       <= 2'b00;
            deb_q         <= 2'b00;
            deb_prev_q    <= 2'b00;
            cnt_q         <= '0;
            bit_valid_q   <= 1'b0;
            bit_value_q   <= 1'b0;
            conflict_q    <= 1'b0;
            pattern_q     <= 4'h0;
            history_q     <= 8'h00;
            bit_count_q   <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_prev_d;
            cnt_q         <= cnt_d;
            bit_valid_q   <= bit_valid_d;
            bit_value_q   <= bit_value_d;
            conflict_q    <= conflict_d;
            pattern_q     <= pattern_d;
            history_q     <= history_d;
            bit_count_q   <= bit_count_d;
            match_count_q <= match_count_d;
        end
    end

    assign Bit_Valid   = bit_valid_q;
    assign Bit_Value   = bit_value_q;
    assign Conflict    = conflict_q;
    assign Pattern     = pattern_q;
    assign History     = history_q;
    assign Bit_Count   = bit_count_q;
    assign Match_Count = match_count_q;
    assign Det_Clear   = (state_q == S_CLR);
    assign Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_entry_ctrl.sv
// Directed bench for seq_entry_ctrl with a short debounce; expected bits are queued when a
// key is pressed and retired against Bit_Valid strobes sampled on the falling clock edge.
module tb_seq_entry_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       P0 = 1'b0, P1 = 1'b0;
    logic [3:0] B = 4'h0;
    logic       Start = 1'b0, Clear_Req = 1'b0, Match = 1'b0;
    logic       Bit_Valid, Bit_Value, Det_Clear, Conflict, Busy;
    logic [3:0] Pattern;
    logic [7:0] History;
    logic [3:0] Bit_Count, Match_Count;

    seq_entry_ctrl #(.DEB_CYCLES(16'd4), .CNT_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .P0(P0), .P1(P1), .B(B),
        .Start(Start), .Clear_Req(Clear_Req), .Match(Match),
        .Bit_Valid(Bit_Valid), .Bit_Value(Bit_Value), .Det_Clear(Det_Clear),
        .Pattern(Pattern), .History(History), .Bit_Count(Bit_Count),
        .Match_Count(Match_Count), .Conflict(Conflict), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int         n_pass = 0, n_fail = 0, n_total = 0;
    int         cyc = 0, n_bv = 0, n_conf = 0, bv_cyc = 0;
    int         pc, nb0, nc0;
    logic       exp_q[$];
    logic [7:0] m_hist = 8'h00;
    logic [3:0] m_cnt = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic e;
        @(negedge Clk);
        cyc++;
        if (Conflict === 1'b1) n_conf++;
        if (Bit_Valid === 1'b1) begin
            n_bv++;
            bv_cyc = cyc;
            chk("bit_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_hist = {m_hist[6:0], e};
                if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
                chk("bit_value", 32'(Bit_Value), 32'(e));
                chk("sb_history", 32'(History), 32'(m_hist));
                chk("sb_bit_count", 32'(Bit_Count), 32'(m_cnt));
            end
        end
    endtask

    task automatic model_clear();
        m_hist = 8'h00;
        m_cnt  = 4'h0;
    endtask

    task automatic press(input logic v);
        if (v) P1 = 1'b1; else P0 = 1'b1;
        exp_q.push_back(v);
        repeat (8) tick();
        P0 = 1'b0;
        P1 = 1'b0;
        repeat (8) tick();
    endtask

    task automatic clear_session(input logic [3:0] pat);
        B = pat;
        Clear_Req = 1'b1;
        model_clear();
        tick();
        chk("clr_det_clear", 32'(Det_Clear), 32'd1);
        Clear_Req = 1'b0;
        tick();
    endtask

    initial begin
        // reset and session start
        repeat (3) tick();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_outputs", 32'({Bit_Valid, Bit_Value, Det_Clear, Conflict, Pattern, History,
                                 Bit_Count, Match_Count}), 32'd0);
        Reset_n = 1'b1;
        tick();
        Match = 1'b1;
        tick();
        Match = 1'b0;
        tick();
        chk("idle_match_ignored", 32'(Match_Count), 32'd0);
        chk("idle_busy", 32'(Busy), 32'd0);
        B = 4'b0110;
        Start = 1'b1;
        tick();
        chk("start_det_clear", 32'(Det_Clear), 32'd1);
        chk("start_busy", 32'(Busy), 32'd1);
        Start = 1'b0;
        tick();
        chk("det_clear_one_cycle", 32'(Det_Clear), 32'd0);
        chk("pattern_latched", 32'(Pattern), 32'h6);
        B = 4'b1111;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        chk("start_in_run_ignored", 32'(Det_Clear), 32'd0);
        chk("pattern_held", 32'(Pattern), 32'h6);

        // clean P1 press: latency and single strobe
        nb0 = n_bv;
        P1 = 1'b1;
        exp_q.push_back(1'b1);
        pc = cyc;
        repeat (10) tick();
        P1 = 1'b0;
        repeat (8) tick();
        chk("p1_latency", 32'(bv_cyc - pc), 32'd7);
        chk("p1_single_strobe", 32'(n_bv - nb0), 32'd1);
        chk("p1_history", 32'(History), 32'h01);
        chk("p1_bit_count", 32'(Bit_Count), 32'd1);

        // bouncing P0 then steady
        nb0 = n_bv;
        for (int i = 0; i < 10; i++) begin
            P0 = (i % 2 == 0);
            repeat (2) tick();
        end
        P0 = 1'b1;
        exp_q.push_back(1'b0);
        repeat (10) tick();
        P0 = 1'b0;
        repeat (8) tick();
        chk("bounce_single_strobe", 32'(n_bv - nb0), 32'd1);
        chk("bounce_history", 32'(History), 32'h02);

        // eight-bit pattern, matches, saturation
        clear_session(4'b0110);
        begin
            logic [7:0] seq_bits;
            seq_bits = 8'b10110110;
            for (int i = 7; i >= 0; i--) press(seq_bits[i]);
        end
        chk("seq_history", 32'(History), 32'hB6);
        chk("seq_bit_count", 32'(Bit_Count), 32'd8);
        repeat (3) begin
            Match = 1'b1;
            tick();
            Match = 1'b0;
            tick();
        end
        chk("match_count", 32'(Match_Count), 32'd3);
        for (int i = 0; i < 20; i++) press(logic'(i % 2));
        chk("bit_count_sat", 32'(Bit_Count), 32'hF);
        chk("sb_drained_4", 32'(exp_q.size()), 32'd0);

        // conflicts: key held across clear, then simultaneous press
        P0 = 1'b1;
        exp_q.push_back(1'b0);
        repeat (8) tick();
        clear_session(4'b0110);
        nb0 = n_bv;
        nc0 = n_conf;
        P1 = 1'b1;
        repeat (10) tick();
        chk("held_conflict", 32'(n_conf - nc0), 32'd1);
        chk("held_no_bit", 32'(n_bv - nb0), 32'd0);
        P0 = 1'b0;
        P1 = 1'b0;
        repeat (8) tick();
        P0 = 1'b1;
        P1 = 1'b1;
        repeat (10) tick();
        chk("both_conflict", 32'(n_conf - nc0), 32'd2);
        chk("both_no_bit", 32'(n_bv - nb0), 32'd0);
        P0 = 1'b0;
        P1 = 1'b0;
        repeat (8) tick();
        press(1'b0);
        chk("after_conflict_count", 32'(Bit_Count), 32'd1);
        chk("after_conflict_history", 32'(History), 32'h00);

        // mid-session clear with new pattern, then async reset mid-press
        press(1'b1);
        Match = 1'b1;
        tick();
        Match = 1'b0;
        tick();
        chk("pre_clear_match", 32'(Match_Count), 32'd1);
        clear_session(4'b1011);
        chk("clear_pattern", 32'(Pattern), 32'hB);
        chk("clear_state", 32'({History, Bit_Count, Match_Count}), 32'd0);
        P1 = 1'b1;
        exp_q.push_back(1'b1);
        repeat (8) tick();
        chk("pre_reset_history", 32'(History), 32'h01);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({Bit_Valid, Bit_Value, Det_Clear, Conflict, Pattern,
                                       History, Bit_Count, Match_Count}), 32'd0);
        chk("async_rst_busy", 32'(Busy), 32'd0);
        repeat (2) tick();
        P1 = 1'b0;
        Reset_n = 1'b1;
        P1 = 1'b1;
        repeat (10) tick();
        P1 = 1'b0;
        repeat (4) tick();
        chk("post_rst_idle", 32'(Busy), 32'd0);
        chk("post_rst_no_bits", 32'(History), 32'd0);
        chk("sb_drained_end", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
